// File: rtl/vscale_dmem_bridge.sv
// vscale data-memory bridge: split-phase pipeline load/store port to a
// registered valid/ready request bus with byte strobes and a one-beat response.
// Misaligned/illegal accesses are trapped locally without a bus transaction.
// Optional bus time-out with response draining: define VSCALE_DMEM_TIMEOUT_EN.
module vscale_dmem_bridge #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dmem_en,
   input  logic        dmem_wen,
   input  logic [2:0]  dmem_size,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata_delayed,
   output logic        dmem_wait,
   output logic [31:0] dmem_rdata,
   output logic        dmem_badmem_e,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic        bus_req_wen,
   output logic [31:0] bus_req_addr,
   output logic [3:0]  bus_req_wstrb,
   output logic [31:0] bus_req_wdata,
   input  logic        bus_resp_valid,
   input  logic [31:0] bus_resp_rdata,
   input  logic        bus_resp_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        wen_q, wen_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        misaligned;
   logic        req_go;   // request actually presented on the bus this cycle
   logic        expire;   // time-out reached this cycle
   logic [3:0]  strb;

   // size[2] carries sign-extension info for the pipeline only
   logic unused_size2;
   assign unused_size2 = dmem_size[2];

   assign misaligned = (dmem_size[1:0] == 2'd3)
                     | ((dmem_size[1:0] == 2'd1) & dmem_addr[0])
                     | ((dmem_size[1:0] == 2'd2) & (dmem_addr[1:0] != 2'b00));

`ifdef VSCALE_DMEM_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       drain_q, drain_d;

   assign expire = (state_q == ISSUE || state_q == WAIT) && (cnt_q == TO_LAST);
   // while a timed-out response is still outstanding, hold off the next request
   assign req_go = (state_q == ISSUE) & ~drain_q;

   // time-out counter and drain flag next state
   always_comb begin
      cnt_d   = cnt_q;
      drain_d = drain_q;
      if (state_d == ISSUE && state_q != ISSUE)
         cnt_d = 8'd0;
      else if (state_q == ISSUE || state_q == WAIT)
         cnt_d = cnt_q + 8'd1;
      // the one response owed to an aborted request is swallowed here
      if (drain_q && bus_resp_valid)
         drain_d = 1'b0;
      // abort after the bus accepted the request: its response is still coming
      if (expire && !bus_resp_valid &&
          (state_q == WAIT || (state_q == ISSUE && req_go && bus_req_ready)))
         drain_d = 1'b1;
   end

   // time-out state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q   <= 8'd0;
         drain_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
      end
   end
`else
   localparam int unused_timeout = TIMEOUT;
   assign expire = 1'b0;
   assign req_go = (state_q == ISSUE);
`endif

   // byte strobes from captured address and size, driven for loads too
   always_comb begin
      unique case (size_q)
         2'd0:    strb = 4'b0001 << addr_q[1:0];
         2'd1:    strb = 4'b0011 << {addr_q[1], 1'b0};
         default: strb = 4'hf;
      endcase
   end

   // FSM next state and capture registers; a completing response beats expiry
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      size_d  = size_q;
      wen_d   = wen_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (dmem_en) begin
               addr_d = dmem_addr;
               size_d = dmem_size[1:0];
               wen_d  = dmem_wen;
               if (misaligned) begin
                  state_d = DONE;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (req_go && bus_req_ready && bus_resp_valid) begin
               state_d = DONE;
               rdata_d = bus_resp_rdata;
               err_d   = bus_resp_err;
            end else if (expire) begin
               state_d = DONE;
               rdata_d = '0;
               err_d   = 1'b1;
            end else if (req_go && bus_req_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus_resp_valid) begin
               state_d = DONE;
               rdata_d = bus_resp_rdata;
               err_d   = bus_resp_err;
            end else if (expire) begin
               state_d = DONE;
               rdata_d = '0;
               err_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and captured access registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         size_q  <= '0;
         wen_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         wen_q   <= wen_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // outputs decode from state so reset forces them all low at once
   assign dmem_wait     = (state_q == ISSUE) || (state_q == WAIT);
   assign dmem_rdata    = (state_q == DONE) ? rdata_q : '0;
   assign dmem_badmem_e = (state_q == DONE) && err_q;
   assign bus_req_valid = req_go;
   assign bus_req_wen   = req_go & wen_q;
   assign bus_req_addr  = req_go ? {addr_q[31:2], 2'b00} : '0;
   assign bus_req_wstrb = req_go ? strb : 4'h0;
   // WB is stalled in ISSUE, so the delayed store data is stable here
   assign bus_req_wdata = req_go ? dmem_wdata_delayed : '0;

endmodule
